// File: rtl/syn_md_pulse_gen_pkg.sv
// Shared constants and FSM encoding for the syn_md burst pulse generator.
package syn_md_pulse_gen_pkg;

    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned NUM_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/syn_md_phase_cnt.sv
// Loadable down-counter timing one HIGH or LOW phase; o_tc_c marks the phase's last cycle.
module syn_md_phase_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // A loaded length L gives L cycles, the last one with the count at 1.
    assign o_tc_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/syn_md_pulse_gen.sv
// Triggered burst generator for the syn_md sync waveform with busy/done status.
module syn_md_pulse_gen
    import syn_md_pulse_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned NUM_W = NUM_W_DEF
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic             trig_en,
    input  logic             stop,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] period_len,
    input  logic [NUM_W-1:0] burst_num,
    output logic             syn_md_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_X_W = CNT_W + 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_high_len;
    logic [CNT_W-1:0] r_low_len;
    logic [NUM_W-1:0] r_pulses;
    logic [NUM_W-1:0] w_pulses_nxt;
    logic             r_syn_md;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_latch;
    logic             w_load;
    logic             w_clr;
    logic [CNT_W-1:0] w_load_val;
    logic             w_tc_c;

    logic [CNT_W-1:0]   w_high_eff;
    logic [CNT_X_W-1:0] w_high_p1_x;
    logic [CNT_X_W-1:0] w_period_x;
    logic [CNT_X_W-1:0] w_period_eff_x;
    logic [CNT_W-1:0]   w_low_len;

    // Effective phase lengths; the period is widened so H+1 cannot overflow.
    assign w_high_eff     = (high_len == '0) ? CNT_W'(1) : high_len;
    assign w_high_p1_x    = CNT_X_W'(w_high_eff) + CNT_X_W'(1);
    assign w_period_x     = CNT_X_W'(period_len);
    assign w_period_eff_x = (w_period_x < w_high_p1_x) ? w_high_p1_x : w_period_x;
    assign w_low_len      = CNT_W'(w_period_eff_x - CNT_X_W'(w_high_eff));

    syn_md_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .i_clr      (w_clr),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_tc_c     (w_tc_c)
    );

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_pulses holds pulses still to start; it is decremented on every HIGH entry.
    always_comb begin
        w_state_nxt  = r_state;
        w_pulses_nxt = r_pulses;
        w_done_nxt   = 1'b0;
        w_latch      = 1'b0;
        w_load       = 1'b0;
        w_clr        = 1'b0;
        w_load_val   = r_high_len;

        if (stop) begin
            w_state_nxt  = ST_IDLE;
            w_pulses_nxt = '0;
            w_clr        = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (trig_en && (burst_num != '0)) begin
                        w_state_nxt  = ST_HIGH;
                        w_latch      = 1'b1;
                        w_load       = 1'b1;
                        w_load_val   = w_high_eff;
                        w_pulses_nxt = burst_num - NUM_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_tc_c) begin
                        if (r_pulses == '0) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = ST_LOW;
                            w_load      = 1'b1;
                            w_load_val  = r_low_len;
                        end
                    end
                end
                ST_LOW: begin
                    if (w_tc_c) begin
                        w_state_nxt  = ST_HIGH;
                        w_load       = 1'b1;
                        w_load_val   = r_high_len;
                        w_pulses_nxt = r_pulses - NUM_W'(1);
                    end
                end
                default: begin
                    w_state_nxt  = ST_IDLE;
                    w_pulses_nxt = '0;
                    w_clr        = 1'b1;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so they align with it.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_syn_md   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pulses   <= '0;
            r_high_len <= '0;
            r_low_len  <= '0;
        end else begin
            r_syn_md <= (w_state_nxt == ST_HIGH);
            r_busy   <= (w_state_nxt != ST_IDLE);
            r_done   <= w_done_nxt;
            r_pulses <= w_pulses_nxt;
            if (w_latch) begin
                r_high_len <= w_high_eff;
                r_low_len  <= w_low_len;
            end
        end
    end

    assign syn_md_out = r_syn_md;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule

// File: tb/tb_syn_md_pulse_gen.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based waveform model.
module tb_syn_md_pulse_gen;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NUM_W = 8;

    logic             clkin      = 1'b0;
    logic             rst_n      = 1'b0;
    logic             trig_en    = 1'b0;
    logic             stop       = 1'b0;
    logic [CNT_W-1:0] high_len   = '0;
    logic [CNT_W-1:0] period_len = '0;
    logic [NUM_W-1:0] burst_num  = '0;
    logic             syn_md_out;
    logic             busy;
    logic             done;

    int n_chk  = 0;
    int n_fail = 0;
    int det_cnt = 0;

    always #5 clkin = ~clkin;

    syn_md_pulse_gen #(
        .CNT_W (CNT_W),
        .NUM_W (NUM_W)
    ) dut (
        .clkin      (clkin),
        .rst_n      (rst_n),
        .trig_en    (trig_en),
        .stop       (stop),
        .high_len   (high_len),
        .period_len (period_len),
        .burst_num  (burst_num),
        .syn_md_out (syn_md_out),
        .busy       (busy),
        .done       (done)
    );

    // Downstream consumer: two-flop synchroniser followed by a registered rising-edge detect.
    logic r_d1, r_d2, r_det;
    always @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            r_d1  <= 1'b0;
            r_d2  <= 1'b0;
            r_det <= 1'b0;
        end else begin
            r_d1  <= syn_md_out;
            r_d2  <= r_d1;
            r_det <= r_d1 & ~r_d2;
        end
    end

    // Model: a queue of {syn, busy, done} for every future cycle of the accepted burst.
    logic [2:0] exp_q[$];
    logic       m_syn  = 1'b0;
    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [3:0] m_hist = '0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int h;
        int p;
        if (!rst_n) begin
            exp_q.delete();
            {m_syn, m_busy, m_done} = 3'b000;
            m_hist = '0;
            return;
        end
        if (stop) begin
            exp_q.delete();
        end else if (!m_busy && trig_en && (burst_num != 0)) begin
            h = (high_len == 0) ? 1 : int'(high_len);
            p = int'(period_len);
            if (p < h + 1) p = h + 1;
            for (int k = 0; k < int'(burst_num); k++) begin
                for (int c = 0; c < h; c++) exp_q.push_back(3'b110);
                if (k < int'(burst_num) - 1)
                    for (int c = 0; c < p - h; c++) exp_q.push_back(3'b010);
            end
            exp_q.push_back(3'b001);
        end
        if (exp_q.size() > 0) {m_syn, m_busy, m_done} = exp_q.pop_front();
        else                  {m_syn, m_busy, m_done} = 3'b000;
        m_hist = {m_hist[2:0], m_syn};
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step();
        #1;
        chk("syn_md_out", syn_md_out, m_syn);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("edge_det", r_det, m_hist[2] & ~m_hist[3]);
        if (r_det) det_cnt++;
    endtask

    task automatic set_cfg(input int h, input int p, input int b);
        high_len   = CNT_W'(h);
        period_len = CNT_W'(p);
        burst_num  = NUM_W'(b);
    endtask

    task automatic fire();
        trig_en = 1'b1;
        tick();
        trig_en = 1'b0;
    endtask

    logic [11:0] seen;

    initial begin
        #2;
        chk("rst_syn", syn_md_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #10;
        rst_n = 1'b1;
        tick();

        // Basic burst: H=3, P=8, two pulses.
        set_cfg(3, 8, 2);
        fire();
        seen = '0;
        seen[0] = syn_md_out;
        for (int i = 1; i < 12; i++) begin
            tick();
            seen[i] = syn_md_out;
            if (i == 11) chk("t1_done", done, 1);
        end
        chk("t1_wave", seen, 12'b0111_0000_0111);
        tick();

        // Zero lengths clamp to 1-high / 1-low.
        set_cfg(0, 0, 3);
        fire();
        seen = '0;
        seen[0] = syn_md_out;
        for (int i = 1; i < 6; i++) begin
            tick();
            seen[i] = syn_md_out;
        end
        chk("t2_wave", seen[5:0], 6'b010101);
        chk("t2_done", done, 1);

        // Retrigger and config change mid-burst, then retrigger in the done cycle.
        set_cfg(2, 5, 2);
        fire();
        repeat (3) tick();
        high_len = CNT_W'(10);
        fire();
        while (!done && n_chk < 100000) tick();
        chk("t3_done_seen", done, 1);
        set_cfg(1, 3, 1);
        fire();
        chk("t3_b2b", syn_md_out, 1);
        repeat (3) tick();

        // Stop during the second HIGH of a 4-pulse burst.
        set_cfg(3, 6, 4);
        fire();
        repeat (6) tick();
        chk("t4_in_high2", syn_md_out, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_syn", syn_md_out, 0);
        chk("t4_stop_busy", busy, 0);
        repeat (8) tick();
        set_cfg(2, 4, 1);
        fire();
        repeat (4) tick();

        // Async reset during a LOW phase.
        set_cfg(2, 10, 3);
        fire();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_syn", syn_md_out, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();

        // trig+stop together in IDLE, and burst_num=0.
        set_cfg(2, 4, 2);
        trig_en = 1'b1;
        stop = 1'b1;
        tick();
        trig_en = 1'b0;
        stop = 1'b0;
        chk("t6_stop_wins", busy, 0);
        repeat (2) tick();
        set_cfg(2, 4, 0);
        fire();
        chk("t6_zero_burst", busy, 0);
        repeat (3) tick();

        // Edge detector sees exactly five rises.
        det_cnt = 0;
        set_cfg(2, 4, 5);
        fire();
        repeat (26) tick();
        chk("t7_det_cnt", det_cnt, 5);

        // Maximum pulse count.
        set_cfg(0, 0, 255);
        fire();
        repeat (515) tick();

        // Random traffic with config churn, retriggers and occasional stops.
        for (int n = 0; n < 3000; n++) begin
            trig_en    = ($urandom_range(0, 7) == 0);
            stop       = ($urandom_range(0, 79) == 0);
            high_len   = CNT_W'($urandom_range(0, 6));
            period_len = CNT_W'($urandom_range(0, 12));
            burst_num  = NUM_W'($urandom_range(0, 4));
            tick();
        end
        trig_en = 1'b0;
        stop    = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
